// File: rtl/hazard_scoreboard.sv
// RAW hazard controller for the ID stage: tracks in-flight destinations in EX/MEM/WB
// slots, stalls IF/ID on a dependency, squashes IF/ID and ID/EX on a taken branch.
module hazard_scoreboard #(
   parameter bit          WB_BYPASS = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_instr_bits_25_21,
   input  logic [4:0]       id_instr_bits_20_16,
   input  logic [4:0]       id_instr_bits_15_11,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_RegDst,
   input  logic             id_RegWrite,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned REG_W = 5;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
   } slot_t;

   slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [REG_W-1:0] id_dest;
   logic             id_wr;
   logic             rs_hit, rt_hit;
   logic             hazard, stall, flush;

   // $zero is never a real dependency, whatever the slot holds
   function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
      return s.valid && (r != '0) && (s.dest == r);
   endfunction

   // Hazard detection and pipeline control, all from current inputs and slot state
   always_comb begin
      id_dest      = id_RegDst ? id_instr_bits_15_11 : id_instr_bits_20_16;
      id_wr        = id_valid & id_RegWrite & (id_dest != '0);

      rs_hit       = slot_match(ex_q, id_instr_bits_25_21) | slot_match(mem_q, id_instr_bits_25_21);
      rt_hit       = slot_match(ex_q, id_instr_bits_20_16) | slot_match(mem_q, id_instr_bits_20_16);
      if (!WB_BYPASS) begin
         rs_hit = rs_hit | slot_match(wb_q, id_instr_bits_25_21);
         rt_hit = rt_hit | slot_match(wb_q, id_instr_bits_20_16);
      end

      hazard       = id_valid & ((id_uses_rs & rs_hit) | (id_uses_rt & rt_hit));
      flush        = ex_branch_taken;
      stall        = hazard & ~flush;

      pc_write     = ~stall;
      if_id_write  = ~stall;
      if_id_flush  = flush;
      id_ex_bubble = stall | flush;
   end

   // Next-state: slots always shift; a stalled or squashed ID enters EX as an empty slot
   always_comb begin
      wb_d        = mem_q;
      mem_d       = ex_q;
      ex_d        = '0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (!(stall | flush)) begin
         ex_d.valid = id_wr;
         ex_d.dest  = id_dest;
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: three instances (WB bypass on/off, narrow counters)
// share directed stimulus; expected control bits and counter values are queued and checked.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, urs, urt, rdst, rw, br;
   logic [4:0] rs, rt, rd;

   logic        pcw_a, ifw_a, ifl_a, bub_a;
   logic        pcw_b, ifw_b, ifl_b, bub_b;
   logic        pcw_c, ifw_c, ifl_c, bub_c;
   logic [15:0] sc_a, fc_a, sc_b, fc_b;
   logic [3:0]  sc_c, fc_c;

   always #5 clk = ~clk;

   hazard_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_instr_bits_25_21(rs), .id_instr_bits_20_16(rt), .id_instr_bits_15_11(rd),
      .id_uses_rs(urs), .id_uses_rt(urt), .id_RegDst(rdst), .id_RegWrite(rw),
      .ex_branch_taken(br), .pc_write(pcw_a), .if_id_write(ifw_a), .if_id_flush(ifl_a),
      .id_ex_bubble(bub_a), .stall_count(sc_a), .flush_count(fc_a));

   hazard_scoreboard #(.WB_BYPASS(1'b0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_instr_bits_25_21(rs), .id_instr_bits_20_16(rt), .id_instr_bits_15_11(rd),
      .id_uses_rs(urs), .id_uses_rt(urt), .id_RegDst(rdst), .id_RegWrite(rw),
      .ex_branch_taken(br), .pc_write(pcw_b), .if_id_write(ifw_b), .if_id_flush(ifl_b),
      .id_ex_bubble(bub_b), .stall_count(sc_b), .flush_count(fc_b));

   hazard_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(4)) u_c (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_instr_bits_25_21(rs), .id_instr_bits_20_16(rt), .id_instr_bits_15_11(rd),
      .id_uses_rs(urs), .id_uses_rt(urt), .id_RegDst(rdst), .id_RegWrite(rw),
      .ex_branch_taken(br), .pc_write(pcw_c), .if_id_write(ifw_c), .if_id_flush(ifl_c),
      .id_ex_bubble(bub_c), .stall_count(sc_c), .flush_count(fc_c));

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       urs;
      logic       urt;
      logic       rdst;
      logic       rw;
   } instr_t;

   typedef struct {
      int         inst;
      int         cyc;
      logic [3:0] ctl;
      int         sc;
      int         fc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   es_a = 0, ef_a = 0, es_b = 0, ef_b = 0, es_c = 0, ef_c = 0;

   function automatic instr_t bub();
      instr_t i = '0;
      return i;
   endfunction

   // writer of rd=d reading $1,$2
   function automatic instr_t wr(input logic [4:0] d);
      instr_t i = '0;
      i.v = 1'b1; i.rd = d; i.rdst = 1'b1; i.rw = 1'b1;
      i.rs = 5'd1; i.rt = 5'd2; i.urs = 1'b1; i.urt = 1'b1;
      return i;
   endfunction

   function automatic instr_t rd_rs(input logic [4:0] r);
      instr_t i = '0;
      i.v = 1'b1; i.rs = r; i.urs = 1'b1;
      return i;
   endfunction

   function automatic instr_t rd_rt(input logic [4:0] r);
      instr_t i = '0;
      i.v = 1'b1; i.rt = r; i.urt = 1'b1;
      return i;
   endfunction

   // One cycle of stimulus; sa = expected stall for bypass instances, sb = no-bypass instance
   task automatic step(input logic r, input instr_t i, input logic b, input logic sa, input logic sb);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_valid = i.v; rs = i.rs; rt = i.rt; rd = i.rd;
      urs = i.urs; urt = i.urt; rdst = i.rdst; rw = i.rw; br = b;
      cyc++;
      e.cyc = cyc;
      e.inst = 0; e.ctl = {~sa, ~sa, b, sa | b}; e.sc = es_a; e.fc = ef_a; q.push_back(e);
      e.inst = 1; e.ctl = {~sb, ~sb, b, sb | b}; e.sc = es_b; e.fc = ef_b; q.push_back(e);
      e.inst = 2; e.ctl = {~sa, ~sa, b, sa | b}; e.sc = es_c; e.fc = ef_c; q.push_back(e);
      if (r) begin
         es_a = 0; ef_a = 0; es_b = 0; ef_b = 0; es_c = 0; ef_c = 0;
      end else begin
         es_a += int'(sa); ef_a += int'(b);
         es_b += int'(sb); ef_b += int'(b);
         if (sa && es_c < 15) es_c++;
         if (b  && ef_c < 15) ef_c++;
      end
   endtask

   exp_t        me;
   logic [3:0]  act;
   logic [31:0] asc, afc;

   // Monitor: compare every queued expectation against the DUT outputs mid-cycle
   always @(negedge clk) begin
      while (q.size() != 0) begin
         me = q.pop_front();
         case (me.inst)
            0:       begin act = {pcw_a, ifw_a, ifl_a, bub_a}; asc = 32'(sc_a); afc = 32'(fc_a); end
            1:       begin act = {pcw_b, ifw_b, ifl_b, bub_b}; asc = 32'(sc_b); afc = 32'(fc_b); end
            default: begin act = {pcw_c, ifw_c, ifl_c, bub_c}; asc = 32'(sc_c); afc = 32'(fc_c); end
         endcase
         tests++;
         if (act !== me.ctl) begin
            fails++;
            $display("FAIL ctl inst%0d cyc%0d: got pcw/ifw/iff/bub=%b want %b",
                     me.inst, me.cyc, act, me.ctl);
         end
         tests++;
         if ((asc !== 32'(me.sc)) || (afc !== 32'(me.fc))) begin
            fails++;
            $display("FAIL cnt inst%0d cyc%0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     me.inst, me.cyc, asc, afc, me.sc, me.fc);
         end
      end
   end

   instr_t sub_i, nw, iv, w7, nr;

   initial begin
      rst = 1'b1; id_valid = 1'b0; rs = '0; rt = '0; rd = '0;
      urs = 1'b0; urt = 1'b0; rdst = 1'b0; rw = 1'b0; br = 1'b0;
      repeat (2) @(posedge clk);
      step(1'b1, bub(), 1'b0, 1'b0, 1'b0);

      // add $3,$1,$2 ; sub $4,$3,$5 held in ID
      sub_i = '0; sub_i.v = 1'b1; sub_i.rs = 5'd3; sub_i.rt = 5'd5; sub_i.rd = 5'd4;
      sub_i.urs = 1'b1; sub_i.urt = 1'b1; sub_i.rdst = 1'b1; sub_i.rw = 1'b1;
      step(1'b0, wr(5'd3), 1'b0, 1'b0, 1'b0);
      step(1'b0, sub_i,    1'b0, 1'b1, 1'b1);
      step(1'b0, sub_i,    1'b0, 1'b1, 1'b1);
      step(1'b0, sub_i,    1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, bub(), 1'b0, 1'b0, 1'b0);

      // $zero writer/reader, non-writing producer, bubble producer
      step(1'b0, wr(5'd0),    1'b0, 1'b0, 1'b0);
      step(1'b0, rd_rs(5'd0), 1'b0, 1'b0, 1'b0);
      nw = wr(5'd3); nw.rw = 1'b0;
      step(1'b0, nw,          1'b0, 1'b0, 1'b0);
      step(1'b0, rd_rs(5'd3), 1'b0, 1'b0, 1'b0);
      iv = wr(5'd5); iv.v = 1'b0;
      step(1'b0, iv,          1'b0, 1'b0, 1'b0);
      step(1'b0, rd_rt(5'd5), 1'b0, 1'b0, 1'b0);

      // rt-side dependency
      step(1'b0, wr(5'd6),    1'b0, 1'b0, 1'b0);
      step(1'b0, rd_rt(5'd6), 1'b0, 1'b1, 1'b1);
      step(1'b0, rd_rt(5'd6), 1'b0, 1'b1, 1'b1);
      step(1'b0, rd_rt(5'd6), 1'b0, 1'b0, 1'b1);
      step(1'b0, bub(),       1'b0, 1'b0, 1'b0);

      // RegDst=0 destination; unused rs field must not match
      w7 = '0; w7.v = 1'b1; w7.rt = 5'd7; w7.rd = 5'd9; w7.rw = 1'b1;
      step(1'b0, w7,          1'b0, 1'b0, 1'b0);
      nr = '0; nr.v = 1'b1; nr.rs = 5'd7; nr.rt = 5'd9; nr.urt = 1'b1;
      step(1'b0, nr,          1'b0, 1'b0, 1'b0);
      step(1'b0, rd_rs(5'd7), 1'b0, 1'b1, 1'b1);
      step(1'b0, rd_rs(5'd7), 1'b0, 1'b0, 1'b1);
      step(1'b0, bub(),       1'b0, 1'b0, 1'b0);

      // taken branch coinciding with a RAW match
      step(1'b0, wr(5'd3),    1'b0, 1'b0, 1'b0);
      step(1'b0, rd_rs(5'd3), 1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, bub(), 1'b0, 1'b0, 1'b0);

      // flush counter saturation on the 4-bit instance
      repeat (20) step(1'b0, bub(), 1'b1, 1'b0, 1'b0);
      step(1'b0, bub(),       1'b0, 1'b0, 1'b0);

      // reset during the first stall cycle
      step(1'b0, wr(5'd3),    1'b0, 1'b0, 1'b0);
      step(1'b1, rd_rs(5'd3), 1'b0, 1'b1, 1'b1);
      step(1'b0, rd_rs(5'd3), 1'b0, 1'b0, 1'b0);
      step(1'b0, bub(),       1'b0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
